sram_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: the IF-stage instruction fetch (read-only) and the MEM-stage data access (read/write).
- Sits between the pipeline and the single-channel sram2axi4_lite bridge feeding AXIMem.
- Serialises transactions with one outstanding transaction total and round-robin on conflict.
- Routes completion pulses and read data back to the owner, and drops the responses of cancelled (flushed) fetches.

---
 rtl/sram_port_arbiter_pkg.sv | 18 +
 rtl/sram_port_arbiter_rr_arb2.sv | 23 ++
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared encodings for the IF/MEM SRAM port arbiter
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    // Level of the reset pin that holds the block in reset.
    localparam logic RestEn = 1'b0;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// rtl/sram_port_arbiter_rr_arb2.sv - two-way round-robin grant between fetch and data
module rr_arb2
    import sram_port_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  gnt_t last_gnt,
    output logic gnt_valid,
    output gnt_t gnt
);

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt       = GNT_INST;
        if (req_i && req_d) begin
            // On conflict the side that did not win last time goes first.
            gnt = (last_gnt == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (req_d) begin
            gnt = GNT_DATA;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between instruction fetch and data access
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_ce,
    input  logic                i_cancel,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rdata_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_ce,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rdata_valid,
    output logic                d_write_finish,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_ce,
    output logic                s_we,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rdata_valid,
    input  logic                s_write_finish
);

    state_t state;
    state_t state_nxt;
    gnt_t   last_gnt;
    gnt_t   arb_gnt;
    logic   arb_valid;
    logic   cancel_flag;
    logic   done;
    logic   i_req;

    // A fetch flushed in the very cycle it is seen is never issued.
    assign i_req = i_ce & ~i_cancel;

    rr_arb2 u_arb (
        .req_i     (i_req),
        .req_d     (d_ce),
        .last_gnt  (last_gnt),
        .gnt_valid (arb_valid),
        .gnt       (arb_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RestEn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = (arb_gnt == GNT_DATA) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                done = s_rdata_valid;
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                done = s_we ? s_write_finish : s_rdata_valid;
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request registers are captured once at grant so s_* stays stable for the transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RestEn) begin
            s_ce        <= 1'b0;
            s_we        <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wmask     <= '0;
            last_gnt    <= GNT_INST;
            cancel_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        s_ce <= 1'b1;
                        if (arb_gnt == GNT_DATA) begin
                            s_addr  <= d_addr;
                            s_we    <= d_we;
                            s_wdata <= d_wdata;
                            s_wmask <= d_wmask;
                        end else begin
                            s_addr  <= i_addr;
                            s_we    <= 1'b0;
                            s_wdata <= '0;
                            s_wmask <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (done) begin
                        s_ce        <= 1'b0;
                        last_gnt    <= GNT_INST;
                        cancel_flag <= 1'b0;
                    end else if (i_cancel) begin
                        cancel_flag <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (done) begin
                        s_ce     <= 1'b0;
                        last_gnt <= GNT_DATA;
                    end
                end
                default: s_ce <= 1'b0;
            endcase
        end
    end

    // Responses go only to the owner; a flushed fetch completes downstream but is swallowed here.
    assign i_rdata        = (state == BUSY_I) ? s_rdata : '0;
    assign i_rdata_valid  = (state == BUSY_I) & s_rdata_valid & ~cancel_flag & ~i_cancel;
    assign d_rdata        = (state == BUSY_D) ? s_rdata : '0;
    assign d_rdata_valid  = (state == BUSY_D) & ~s_we & s_rdata_valid;
    assign d_write_finish = (state == BUSY_D) & s_we & s_write_finish;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr;
    logic        i_ce;
    logic        i_cancel;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic [31:0] d_addr;
    logic        d_ce;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic        d_write_finish;
    logic [31:0] s_addr;
    logic        s_ce;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic [31:0] s_rdata;
    logic        s_rdata_valid;
    logic        s_write_finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_addr         (i_addr),
        .i_ce           (i_ce),
        .i_cancel       (i_cancel),
        .i_rdata        (i_rdata),
        .i_rdata_valid  (i_rdata_valid),
        .d_addr         (d_addr),
        .d_ce           (d_ce),
        .d_we           (d_we),
        .d_wdata        (d_wdata),
        .d_wmask        (d_wmask),
        .d_rdata        (d_rdata),
        .d_rdata_valid  (d_rdata_valid),
        .d_write_finish (d_write_finish),
        .s_addr         (s_addr),
        .s_ce           (s_ce),
        .s_we           (s_we),
        .s_wdata        (s_wdata),
        .s_wmask        (s_wmask),
        .s_rdata        (s_rdata),
        .s_rdata_valid  (s_rdata_valid),
        .s_write_finish (s_write_finish)
    );

    typedef struct {
        logic        i_ce, i_cancel;
        logic [31:0] i_addr;
        logic        d_ce, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [3:0]  d_wmask;
        logic [31:0] s_rdata;
        logic        srv, swf;
        logic        chk_s;
        logic        e_sce, e_swe;
        logic [31:0] e_saddr, e_swdata;
        logic [3:0]  e_swmask;
        logic        e_iv;
        logic [31:0] e_irdata;
        logic        e_dv;
        logic [31:0] e_drdata;
        logic        e_dwf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ic, input logic icn, input logic [31:0] ia,
        input logic dc, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
        input logic [3:0] dm, input logic [31:0] sr, input logic srv, input logic swf,
        input logic cs, input logic esce, input logic eswe, input logic [31:0] esa,
        input logic [31:0] eswd, input logic [3:0] esm, input logic eiv,
        input logic [31:0] eir, input logic edv, input logic [31:0] edr, input logic edwf);
        vec_t v;
        v.i_ce = ic; v.i_cancel = icn; v.i_addr = ia;
        v.d_ce = dc; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd; v.d_wmask = dm;
        v.s_rdata = sr; v.srv = srv; v.swf = swf; v.chk_s = cs;
        v.e_sce = esce; v.e_swe = eswe; v.e_saddr = esa; v.e_swdata = eswd; v.e_swmask = esm;
        v.e_iv = eiv; v.e_irdata = eir; v.e_dv = edv; v.e_drdata = edr; v.e_dwf = edwf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_ce = 0; i_cancel = 0; i_addr = 0;
        d_ce = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        s_rdata = 0; s_rdata_valid = 0; s_write_finish = 0;
    endtask

    logic [31:0] fair_addr[4];

    initial begin
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_ce", {31'd0, s_ce}, 0);
        chk("rst s_we", {31'd0, s_we}, 0);
        chk("rst s_addr", s_addr, 0);
        chk("rst s_wdata", s_wdata, 0);
        chk("rst s_wmask", {28'd0, s_wmask}, 0);
        chk("rst pulses", {29'd0, i_rdata_valid, d_rdata_valid, d_write_finish}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // fetch alone, response 3 cycles after s_ce rises
        vecs.push_back(mk(1,0,32'h1c000000, 0,0,0,0,0, 0,0,0, 0, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h1c000000, 0,0,0,0,0, 0,0,0, 1, 1,0,32'h1c000000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h1c000000, 0,0,0,0,0, 0,0,0, 1, 1,0,32'h1c000000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h1c000000, 0,0,0,0,0, 0,0,0, 1, 1,0,32'h1c000000,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h1c000000, 0,0,0,0,0, 32'h02800c0c,1,0, 1, 1,0,32'h1c000000,0,0, 1,32'h02800c0c,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0, 0,0,0,0,0, 0,0,0,0,0));
        // store; stray read pulse ignored; d_addr/d_wdata change mid-transaction
        vecs.push_back(mk(0,0,0, 1,1,32'h1c000100,32'hdeadbeef,4'h3, 0,0,0, 0, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'h1c000100,32'hdeadbeef,4'h3, 0,1,0, 1, 1,1,32'h1c000100,32'hdeadbeef,4'h3, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'h0,32'h0,4'h3, 0,0,0, 1, 1,1,32'h1c000100,32'hdeadbeef,4'h3, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'h0,32'h0,4'h3, 0,0,1, 1, 1,1,32'h1c000100,32'hdeadbeef,4'h3, 0,0,0,0,1));
        // stray completions while idle
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,1, 0, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,1,0, 0, 0,0,0,0,0, 0,0,0,0,0));
        // load; stray write pulse ignored
        vecs.push_back(mk(0,0,0, 1,0,32'h1c000200,0,0, 0,0,0, 0, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,0,32'h1c000200,0,0, 0,0,1, 1, 1,0,32'h1c000200,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 1,0,32'h1c000200,0,0, 32'h12345678,1,0, 1, 1,0,32'h1c000200,0,0, 0,0,1,32'h12345678,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0, 0,0,0,0,0, 0,0,0,0,0));

        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk); #1;
            i_ce = vecs[n].i_ce; i_cancel = vecs[n].i_cancel; i_addr = vecs[n].i_addr;
            d_ce = vecs[n].d_ce; d_we = vecs[n].d_we; d_addr = vecs[n].d_addr;
            d_wdata = vecs[n].d_wdata; d_wmask = vecs[n].d_wmask;
            s_rdata = vecs[n].s_rdata; s_rdata_valid = vecs[n].srv; s_write_finish = vecs[n].swf;
            @(negedge clk);
            chk($sformatf("v%0d s_ce", n), {31'd0, s_ce}, {31'd0, vecs[n].e_sce});
            chk($sformatf("v%0d i_rdata_valid", n), {31'd0, i_rdata_valid}, {31'd0, vecs[n].e_iv});
            chk($sformatf("v%0d i_rdata", n), i_rdata, vecs[n].e_irdata);
            chk($sformatf("v%0d d_rdata_valid", n), {31'd0, d_rdata_valid}, {31'd0, vecs[n].e_dv});
            chk($sformatf("v%0d d_rdata", n), d_rdata, vecs[n].e_drdata);
            chk($sformatf("v%0d d_write_finish", n), {31'd0, d_write_finish}, {31'd0, vecs[n].e_dwf});
            if (vecs[n].chk_s) begin
                chk($sformatf("v%0d s_we", n), {31'd0, s_we}, {31'd0, vecs[n].e_swe});
                chk($sformatf("v%0d s_addr", n), s_addr, vecs[n].e_saddr);
                chk($sformatf("v%0d s_wdata", n), s_wdata, vecs[n].e_swdata);
                chk($sformatf("v%0d s_wmask", n), {28'd0, s_wmask}, {28'd0, vecs[n].e_swmask});
            end
        end

        // conflict fairness from reset release: D, I, D, I with one idle cycle between
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b0;
        i_ce = 1; i_addr = 32'h100; d_ce = 1; d_we = 0; d_addr = 32'h200;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("fair idle after release", {31'd0, s_ce}, 0);
        fair_addr[0] = 32'h200; fair_addr[1] = 32'h100; fair_addr[2] = 32'h200; fair_addr[3] = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("fair%0d s_ce", k), {31'd0, s_ce}, 1);
            chk($sformatf("fair%0d owner", k), s_addr, fair_addr[k]);
            @(posedge clk); #1 s_rdata_valid = 1; s_rdata = 32'ha0 + k;
            @(negedge clk);
            chk($sformatf("fair%0d i_v", k), {31'd0, i_rdata_valid}, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("fair%0d d_v", k), {31'd0, d_rdata_valid}, (k % 2 == 0) ? 1 : 0);
            @(posedge clk); #1 s_rdata_valid = 0;
            @(negedge clk);
            chk($sformatf("fair%0d gap", k), {31'd0, s_ce}, 0);
        end
        i_ce = 0; d_ce = 0;

        // fetch cancelled in the same idle cycle is never issued
        @(posedge clk); #1 i_ce = 1; i_cancel = 1; i_addr = 32'h300;
        @(posedge clk); #1 i_cancel = 0;
        @(negedge clk);
        chk("cancel same cycle", {31'd0, s_ce}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch after cancel s_ce", {31'd0, s_ce}, 1);
        chk("fetch after cancel addr", s_addr, 32'h300);
        // flush one cycle after grant, data request pending behind it
        @(posedge clk); #1 i_cancel = 1; i_ce = 0; d_ce = 1; d_we = 0; d_addr = 32'h400;
        @(negedge clk);
        chk("cancel pulse i_v", {31'd0, i_rdata_valid}, 0);
        @(posedge clk); #1 i_cancel = 0;
        @(posedge clk); #1 s_rdata_valid = 1; s_rdata = 32'hcafef00d;
        @(negedge clk);
        chk("cancel swallowed", {31'd0, i_rdata_valid}, 0);
        chk("cancel no d_v", {31'd0, d_rdata_valid}, 0);
        @(posedge clk); #1 s_rdata_valid = 0;
        @(negedge clk);
        chk("cancel gap", {31'd0, s_ce}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pending d granted", {31'd0, s_ce}, 1);
        chk("pending d addr", s_addr, 32'h400);
        @(posedge clk); #1 s_rdata_valid = 1; s_rdata = 32'h55aa;
        @(negedge clk);
        chk("pending d_v", {31'd0, d_rdata_valid}, 1);
        chk("pending d_rdata", d_rdata, 32'h55aa);
        @(posedge clk); #1 s_rdata_valid = 0; d_ce = 0;

        // reset while in BUSY_D
        @(posedge clk); #1 d_ce = 1; d_addr = 32'h500;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_d before reset", {31'd0, s_ce}, 1);
        #2 reset = 1'b0; d_ce = 0;
        #1;
        chk("reset async s_ce", {31'd0, s_ce}, 0);
        chk("reset async s_addr", s_addr, 0);
        @(posedge clk); #1 reset = 1'b1; s_rdata_valid = 1; s_rdata = 32'h77;
        @(negedge clk);
        chk("stray after reset d_v", {31'd0, d_rdata_valid}, 0);
        chk("stray after reset s_ce", {31'd0, s_ce}, 0);
        @(posedge clk); #1 s_rdata_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
